// File: rtl/reflet_mem_sequencer.sv
// reflet_mem_sequencer: sequences 8/16-bit CPU loads and stores onto a byte-wide
// memory with one-cycle read latency. A word access takes two byte cycles (A, A+1).
// Optional feature: define REFLET_MISALIGN_TRAP_EN to fault misaligned word accesses
// when trap_en is set at acceptance; otherwise misaligned words are simply split.
module reflet_mem_sequencer #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              trap_en,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StAcc1,
`ifdef REFLET_MISALIGN_TRAP_EN
        StFault,
`endif
        StResp
    } state_e;

    state_e            state_q;
    logic              word_q;
    logic              write_q;
    logic [7:0]        wdata_hi_q;
    logic [7:0]        byte0_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              resp_valid_q;
    logic              trap_req;

`ifdef REFLET_MISALIGN_TRAP_EN
    logic              fault_q;
    assign trap_req = req_word && req_addr[0] && trap_en;
`else
    logic              unused_trap_en;
    assign unused_trap_en = trap_en;
    assign trap_req       = 1'b0;
`endif

    // Sequencer FSM with registered memory and response strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            word_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_hi_q   <= 8'h00;
            byte0_q      <= 8'h00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
            resp_valid_q <= 1'b0;
`ifdef REFLET_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    mem_en_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        word_q     <= req_word;
                        write_q    <= req_write;
                        wdata_hi_q <= req_wdata[15:8];
                        if (trap_req) begin
`ifdef REFLET_MISALIGN_TRAP_EN
                            state_q      <= StFault;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b1;
`endif
                        end else begin
                            state_q     <= StAcc0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_wdata[7:0];
                        end
                    end
                end
                StAcc0: begin
                    if (word_q) begin
                        // Second byte wraps naturally at the top of the address space.
                        state_q     <= StAcc1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= wdata_hi_q;
                    end else begin
                        state_q      <= StResp;
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end
                end
                StAcc1: begin
                    byte0_q      <= mem_rdata;
                    state_q      <= StResp;
                    mem_en_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                StResp: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                end
`ifdef REFLET_MISALIGN_TRAP_EN
                StFault: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    mem_en_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by reset so an aborted access issues no further write or response.
    assign req_ready  = (state_q == StIdle);
    assign mem_en     = mem_en_q && !reset;
    assign mem_we     = mem_we_q && !reset;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q && !reset;
`ifdef REFLET_MISALIGN_TRAP_EN
    assign fault      = fault_q && !reset;
`else
    assign fault      = 1'b0;
`endif

    // Last load byte comes straight from the memory in the response cycle.
    always_comb begin
        resp_rdata = 16'h0000;
        if (resp_valid && !write_q && !fault) begin
            resp_rdata = word_q ? {mem_rdata, byte0_q} : {8'h00, mem_rdata};
        end
    end

endmodule

// File: tb/tb_reflet_mem_sequencer.sv
// Bench for reflet_mem_sequencer: byte memory model, cycle-timeline reference model,
// directed cases with literal expectations and a randomized per-cycle stimulus phase.
module tb_reflet_mem_sequencer;

    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        trap_en;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        fault;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;

    logic [7:0] mem_arr [65536];
    logic [7:0] ref_mem [65536];

    // Expected timeline, one entry per cycle.
    bit          exp_ready [NCYC];
    bit          exp_en    [NCYC];
    bit          exp_we    [NCYC];
    logic [15:0] exp_addr  [NCYC];
    logic [7:0]  exp_wdata [NCYC];
    bit          exp_rv    [NCYC];
    bit          exp_fault [NCYC];
    logic [15:0] exp_rdata [NCYC];

    reflet_mem_sequencer #(.ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_word   (req_word),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .trap_en    (trap_en),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .fault      (fault),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Byte memory: 1-cycle registered read, write on enable+strobe.
    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = init_byte(i);
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                mem_rdata <= mem_arr[mem_addr];
                if (mem_we === 1'b1) mem_arr[mem_addr] = mem_wdata;
            end
        end
    end

    // Reference model and per-cycle comparison.
    initial begin
        int c;
        logic [15:0] a;
        logic [15:0] a1;
        bit trapped;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        for (int i = 0; i < NCYC; i++) begin
            exp_ready[i] = 1; exp_en[i] = 0; exp_we[i] = 0; exp_addr[i] = 0;
            exp_wdata[i] = 0; exp_rv[i] = 0; exp_fault[i] = 0; exp_rdata[i] = 0;
        end
        forever begin
            @(negedge clk);
            c = cyc;
            if (c + 4 >= NCYC) begin
                $display("FAIL cycle_budget cyc=%0d actual=%0d required<%0d", c, c, NCYC - 4);
                errors++;
                $fatal(1, "cycle budget exhausted");
            end
            if (reset === 1'b1) begin
                if (started) chk("ready_in_reset", 32'(req_ready), 32'(exp_ready[c]));
                chk("rst_mem_en", 32'(mem_en), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                for (int k = 1; k <= 3; k++) begin
                    exp_ready[c+k] = 1; exp_en[c+k] = 0; exp_we[c+k] = 0;
                    exp_rv[c+k] = 0; exp_fault[c+k] = 0; exp_rdata[c+k] = 0;
                end
                started = 1;
            end else if (started) begin
                chk("req_ready", 32'(req_ready), 32'(exp_ready[c]));
                chk("mem_en", 32'(mem_en), 32'(exp_en[c]));
                chk("mem_we", 32'(mem_we), 32'(exp_we[c]));
                chk("resp_valid", 32'(resp_valid), 32'(exp_rv[c]));
                chk("fault", 32'(fault), 32'(exp_fault[c]));
                chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata[c]));
                if (exp_en[c]) begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr[c]));
                    if (exp_we[c]) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata[c]));
                end
                if (exp_en[c] && exp_we[c]) ref_mem[exp_addr[c]] = exp_wdata[c];
                if (req_valid === 1'b1 && exp_ready[c]) begin
                    a  = req_addr;
                    a1 = a + 16'd1;
                    trapped = 0;
`ifdef REFLET_MISALIGN_TRAP_EN
                    trapped = req_word && a[0] && trap_en;
`endif
                    exp_ready[c+1] = 0;
                    if (trapped) begin
                        exp_rv[c+1] = 1; exp_fault[c+1] = 1; exp_rdata[c+1] = 0;
                    end else begin
                        exp_en[c+1] = 1; exp_we[c+1] = req_write;
                        exp_addr[c+1] = a; exp_wdata[c+1] = req_wdata[7:0];
                        exp_ready[c+2] = 0;
                        if (req_word) begin
                            exp_en[c+2] = 1; exp_we[c+2] = req_write;
                            exp_addr[c+2] = a1; exp_wdata[c+2] = req_wdata[15:8];
                            exp_ready[c+3] = 0; exp_rv[c+3] = 1;
                            exp_rdata[c+3] = req_write ? 16'h0 : {ref_mem[a1], ref_mem[a]};
                        end else begin
                            exp_rv[c+2] = 1;
                            exp_rdata[c+2] = req_write ? 16'h0 : {8'h00, ref_mem[a]};
                        end
                    end
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic wd, input logic [15:0] a,
                          input logic [15:0] d, input logic te,
                          output logic [15:0] rd, output logic f, output int lat);
        bit acc;
        acc = 0; lat = -1; rd = 16'h0; f = 1'b0;
        @(posedge clk); #1;
        req_valid = 1; req_write = w; req_word = wd; req_addr = a; req_wdata = d; trap_en = te;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) acc = 1;
            else begin @(posedge clk); #1; end
        end
        chk("accepted", 32'(acc), 32'd1);
        if (acc) begin
            // Scramble request inputs after acceptance; they must be ignored.
            @(posedge clk); #1;
            req_valid = 0; req_write = ~w; req_word = ~wd; req_addr = ~a;
            req_wdata = ~d; trap_en = ~te;
            for (int k = 1; k <= 8 && lat < 0; k++) begin
                @(negedge clk);
                if (resp_valid === 1'b1) begin
                    lat = k; rd = resp_rdata; f = fault;
                end
            end
            chk("resp_seen", 32'(lat > 0), 32'd1);
        end else begin
            req_valid = 0;
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        f;
        int          lat;
        int          nresp;
        int          nacc;
        bit          acc;
        reset = 1; req_valid = 0; req_write = 0; req_word = 0;
        req_addr = 0; req_wdata = 0; trap_en = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rdata", 32'(resp_rdata), 32'd0);

        // Word load of two preloaded bytes.
        do_req(1, 0, 16'h0004, 16'h003D, 0, rd, f, lat);
        do_req(1, 0, 16'h0005, 16'h0002, 0, rd, f, lat);
        chk("byte_store_lat", 32'(lat), 32'd2);
        do_req(0, 1, 16'h0004, 16'h0000, 0, rd, f, lat);
        chk("word_load_data", 32'(rd), 32'h023D);
        chk("word_load_lat", 32'(lat), 32'd3);

        // Word store and read-back.
        do_req(1, 1, 16'h0010, 16'hBEEF, 0, rd, f, lat);
        chk("word_store_lat", 32'(lat), 32'd3);
        chk("word_store_rdata", 32'(rd), 32'h0);
        do_req(0, 1, 16'h0010, 16'h0000, 0, rd, f, lat);
        chk("readback", 32'(rd), 32'hBEEF);

        // Misaligned word load, trap enabled then disabled.
        do_req(1, 0, 16'h0001, 16'h0011, 0, rd, f, lat);
        do_req(1, 0, 16'h0002, 16'h0022, 0, rd, f, lat);
        do_req(0, 1, 16'h0001, 16'h0000, 1, rd, f, lat);
`ifdef REFLET_MISALIGN_TRAP_EN
        chk("trap_fault", 32'(f), 32'd1);
        chk("trap_lat", 32'(lat), 32'd1);
        chk("trap_rdata", 32'(rd), 32'h0);
`else
        chk("notrap_fault", 32'(f), 32'd0);
        chk("notrap_lat", 32'(lat), 32'd3);
        chk("notrap_rdata", 32'(rd), 32'h2211);
`endif
        do_req(0, 1, 16'h0001, 16'h0000, 0, rd, f, lat);
        chk("split_fault", 32'(f), 32'd0);
        chk("split_lat", 32'(lat), 32'd3);
        chk("split_rdata", 32'(rd), 32'h2211);

        // Top-of-memory byte and wrapping word.
        do_req(1, 0, 16'hFFFF, 16'h00A5, 0, rd, f, lat);
        do_req(1, 0, 16'h0000, 16'h0077, 0, rd, f, lat);
        do_req(0, 0, 16'hFFFF, 16'h0000, 0, rd, f, lat);
        chk("top_byte_rdata", 32'(rd), 32'h00A5);
        chk("top_byte_lat", 32'(lat), 32'd2);
        do_req(0, 1, 16'hFFFF, 16'h0000, 0, rd, f, lat);
        chk("wrap_word_rdata", 32'(rd), 32'h77A5);

        // Reset in the second byte cycle of a word store.
        do_req(1, 0, 16'h0020, 16'h0000, 0, rd, f, lat);
        do_req(1, 0, 16'h0021, 16'h0000, 0, rd, f, lat);
        @(posedge clk); #1;
        req_valid = 1; req_write = 1; req_word = 1; req_addr = 16'h0020; req_wdata = 16'h1234;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) acc = 1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_accepted", 32'(acc), 32'd1);
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("abort_byte_a", 32'(mem_arr[16'h0020]), 32'h34);
        chk("abort_byte_a1", 32'(mem_arr[16'h0021]), 32'h00);

        // Back-to-back byte loads with valid held high.
        do_req(0, 0, 16'h0004, 16'h0000, 0, rd, f, lat);
        nresp = 0; nacc = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = 0; req_word = 0; req_addr = 16'h0004; trap_en = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) nresp++;
            if (req_ready === 1'b1) nacc++;
            @(posedge clk); #1;
        end
        req_valid = 0;
        chk("b2b_resp_count", 32'(nresp), 32'd3);
        chk("b2b_accept_count", 32'(nacc), 32'd3);

        // Randomized per-cycle stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 99) < 2);
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = $urandom_range(0, 1) == 1;
            req_word  = $urandom_range(0, 1) == 1;
            req_addr  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                    : 16'($urandom_range(0, 63));
            req_wdata = 16'($urandom);
            trap_en   = $urandom_range(0, 1) == 1;
        end
        @(posedge clk); #1;
        reset = 0; req_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
